// File: rtl/tinyqv_instr_buffer.sv
// tinyqv_instr_buffer: prefetch halfword queue presenting aligned 16/32-bit instructions
// to the decoder, tracking the fetch address and the current instruction PC.
module tinyqv_instr_buffer #(
   parameter int DEPTH   = 4,
   parameter int PC_BITS = 24
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      flush,
   input  logic [PC_BITS-1:0]        new_pc,
   input  logic [15:0]               data_in,
   input  logic                      data_in_valid,
   output logic                      data_in_ready,
   output logic [PC_BITS-1:0]        fetch_pc,
   output logic [31:0]               instr,
   output logic                      instr_valid,
   output logic [2:0]                instr_len,
   output logic [PC_BITS-1:0]        instr_pc,
   input  logic                      instr_advance,
   output logic [$clog2(DEPTH):0]    level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [15:0]        mem_q [DEPTH];
   logic [AW-1:0]      rp_q, wp_q, rp1;
   logic [LW-1:0]      level_q, level_d;
   logic [PC_BITS-1:0] fetch_pc_q, instr_pc_q;
   logic               c, push, pop;

   // rp1 wraps naturally, so a 32-bit instruction at DEPTH-1 takes its upper half from mem[0]
   assign rp1           = rp_q + 1'b1;
   assign c             = mem_q[rp_q][1:0] != 2'b11;
   assign instr_len     = c ? 3'd2 : 3'd4;
   assign instr         = {level_q >= LW'(2) ? mem_q[rp1] : 16'h0,
                           level_q != '0     ? mem_q[rp_q] : 16'h0};
   assign instr_valid   = (level_q != '0 && c) || level_q >= LW'(2);
   assign data_in_ready = level_q < LW'(DEPTH);
   assign push          = data_in_valid && data_in_ready && !flush;
   assign pop           = instr_advance && instr_valid && !flush;
   assign level_d       = level_q + LW'(push) - (pop ? (c ? LW'(1) : LW'(2)) : LW'(0));
   assign level         = level_q;
   assign fetch_pc      = fetch_pc_q;
   assign instr_pc      = instr_pc_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rp_q       <= '0;
         wp_q       <= '0;
         level_q    <= '0;
         fetch_pc_q <= '0;
         instr_pc_q <= '0;
      end else if (flush) begin
         rp_q       <= '0;
         wp_q       <= '0;
         level_q    <= '0;
         fetch_pc_q <= {new_pc[PC_BITS-1:1], 1'b0};
         instr_pc_q <= {new_pc[PC_BITS-1:1], 1'b0};
      end else begin
         if (push) begin
            mem_q[wp_q] <= data_in;
            wp_q        <= wp_q + 1'b1;
            fetch_pc_q  <= fetch_pc_q + PC_BITS'(2);
         end
         if (pop) begin
            rp_q       <= rp_q + (c ? AW'(1) : AW'(2));
            instr_pc_q <= instr_pc_q + PC_BITS'(instr_len);
         end
         level_q <= level_d;
      end
   end
endmodule

// File: tb/tb_tinyqv_instr_buffer.sv
// tb_tinyqv_instr_buffer: directed and randomized checks of the instruction buffer
// against a queue-based model of the halfword stream.
module tb_tinyqv_instr_buffer;
   localparam int DEPTH = 4;
   localparam int PB    = 24;

   logic          clk = 0, rstn = 0, flush = 0, dv = 0, adv = 0;
   logic [PB-1:0] new_pc = '0;
   logic [15:0]   din = '0;
   logic          data_in_ready, instr_valid;
   logic [PB-1:0] fetch_pc, instr_pc;
   logic [31:0]   instr;
   logic [2:0]    instr_len;
   logic [2:0]    level;

   int checks = 0, failures = 0;
   logic [15:0]   q[$];
   logic [PB-1:0] m_ipc = '0, m_fpc = '0;

   tinyqv_instr_buffer #(.DEPTH(DEPTH), .PC_BITS(PB)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .new_pc(new_pc),
      .data_in(din), .data_in_valid(dv), .data_in_ready(data_in_ready),
      .fetch_pc(fetch_pc), .instr(instr), .instr_valid(instr_valid),
      .instr_len(instr_len), .instr_pc(instr_pc), .instr_advance(adv), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit m_valid();
      return (q.size() >= 1 && q[0][1:0] != 2'b11) || q.size() >= 2;
   endfunction

   function automatic int m_len();
      return (q.size() >= 1 && q[0][1:0] == 2'b11) ? 4 : 2;
   endfunction

   task automatic compare();
      logic [31:0] w;
      w = {q.size() >= 2 ? q[1] : 16'h0, q.size() >= 1 ? q[0] : 16'h0};
      chk("level", 32'(level), 32'(q.size()));
      chk("ready", 32'(data_in_ready), 32'(q.size() < DEPTH));
      chk("valid", 32'(instr_valid), 32'(m_valid()));
      chk("instr", instr, w);
      chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
      if (q.size() >= 1) chk("len", 32'(instr_len), 32'(m_len()));
   endtask

   // Drive one cycle of inputs, advance the model on the edge, compare on the next negedge
   task automatic step(input logic d_v, input logic [15:0] d, input logic a,
                       input logic f, input logic [PB-1:0] np);
      bit v, pu;
      int n;
      dv = d_v; din = d; adv = a; flush = f; new_pc = np;
      v  = m_valid();
      n  = m_len();
      pu = d_v && q.size() < DEPTH;
      @(posedge clk);
      if (f) begin
         q.delete();
         m_ipc = {np[PB-1:1], 1'b0};
         m_fpc = m_ipc;
      end else begin
         if (a && v) begin
            for (int i = 0; i < n / 2; i++) void'(q.pop_front());
            m_ipc = m_ipc + PB'(n);
         end
         if (pu) begin
            q.push_back(d);
            m_fpc = m_fpc + PB'(2);
         end
      end
      @(negedge clk);
      dv = 0; adv = 0; flush = 0;
      compare();
   endtask

   initial begin
      logic [15:0] hw [6];
      int          exp_pc [4];
      logic [31:0] exp_w [4];
      logic [31:0] exp_m [4];
      int          k, pops;
      bit          a, acc;

      repeat (2) @(negedge clk);
      chk("rst_level", 32'(level), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_instr", instr, 0);
      chk("rst_len", 32'(instr_len), 2);
      chk("rst_ready", 32'(data_in_ready), 1);
      chk("rst_pcs", 32'({fetch_pc, instr_pc}), 0);
      rstn = 1;
      compare();

      step(1, 16'h0001, 0, 0, 0);
      chk("cnop_valid", 32'(instr_valid), 1);
      chk("cnop_instr", instr, 32'h00000001);
      chk("cnop_len", 32'(instr_len), 2);
      chk("cnop_ipc", 32'(instr_pc), 0);
      chk("cnop_fpc", 32'(fetch_pc), 2);

      step(0, 0, 0, 1, 24'h000100);
      step(1, 16'h0093, 0, 0, 0);
      chk("addi_half_valid", 32'(instr_valid), 0);
      step(1, 16'h0010, 0, 0, 0);
      chk("addi_valid", 32'(instr_valid), 1);
      chk("addi_instr", instr, 32'h00100093);
      chk("addi_len", 32'(instr_len), 4);
      step(0, 0, 1, 0, 0);
      chk("addi_adv_ipc", 32'(instr_pc), 32'h000104);
      chk("addi_adv_level", 32'(level), 0);

      step(0, 0, 0, 1, 0);
      step(1, 16'h0013, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0);
      step(1, 16'h0013, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0);
      chk("full_level", 32'(level), 4);
      chk("full_ready", 32'(data_in_ready), 0);
      step(1, 16'h1234, 0, 0, 0);
      chk("full_refused", 32'(level), 4);
      step(1, 16'h5678, 1, 0, 0);
      chk("full_pop_level", 32'(level), 2);
      chk("full_pop_ready", 32'(data_in_ready), 1);
      chk("full_pop_instr", instr, 32'h00000013);

      step(0, 0, 0, 1, 0);
      hw     = '{16'h4501, 16'h0513, 16'h00a0, 16'h0593, 16'h00b0, 16'h0001};
      exp_pc = '{0, 2, 6, 10};
      exp_w  = '{32'h4501, 32'h00a00513, 32'h00b00593, 32'h0001};
      exp_m  = '{32'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF};
      k = 0; pops = 0;
      for (int cy = 0; cy < 20 && pops < 4; cy++) begin
         a   = m_valid();
         acc = k < 6 && q.size() < DEPTH;
         if (a) begin
            chk("wrap_pc", 32'(instr_pc), 32'(exp_pc[pops]));
            chk("wrap_instr", instr & exp_m[pops], exp_w[pops]);
            pops++;
         end
         step(k < 6, k < 6 ? hw[k] : 16'h0, a, 0, 0);
         if (acc) k++;
      end
      chk("wrap_pops", 32'(pops), 4);

      step(1, 16'h0001, 0, 0, 0);
      step(1, 16'h0002, 0, 0, 0);
      step(1, 16'hABCD, 1, 1, 24'h000103);
      chk("flush_level", 32'(level), 0);
      chk("flush_valid", 32'(instr_valid), 0);
      chk("flush_ipc", 32'(instr_pc), 32'h000102);
      chk("flush_fpc", 32'(fetch_pc), 32'h000102);
      step(0, 0, 0, 0, 0);
      chk("flush_nothing_kept", 32'(level), 0);

      step(0, 0, 0, 1, 24'hFFFFFC);
      step(1, 16'h0013, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0);
      chk("pcwrap_ipc", 32'(instr_pc), 32'hFFFFFC);
      chk("pcwrap_fpc", 32'(fetch_pc), 0);
      step(0, 0, 1, 0, 0);
      chk("pcwrap_adv_ipc", 32'(instr_pc), 0);

      step(1, 16'h0001, 0, 0, 0);
      step(1, 16'h0001, 1, 0, 0);
      #2 rstn = 0;
      #1;
      chk("arst_level", 32'(level), 0);
      chk("arst_valid", 32'(instr_valid), 0);
      chk("arst_instr", instr, 0);
      chk("arst_len", 32'(instr_len), 2);
      chk("arst_ready", 32'(data_in_ready), 1);
      chk("arst_ipc", 32'(instr_pc), 0);
      chk("arst_fpc", 32'(fetch_pc), 0);
      q.delete();
      m_ipc = '0;
      m_fpc = '0;
      @(negedge clk);
      rstn = 1;
      compare();

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 3, PB'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
